// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and magnitude helper for the H-bridge PWM driver
package pwm_pkg;

  localparam int DUTY_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    DEAD = 2'd3
  } pwm_state_t;

  typedef struct packed {
    logic              sat;
    logic [DUTY_W-1:0] mag;
  } mag_t;

  // Magnitude is formed at DUTY_W+1 bits so that the most negative command has a representable abs value.
  function automatic mag_t abs_clamp(input logic [DUTY_W-1:0] v, input logic [DUTY_W:0] limit);
    logic [DUTY_W:0] m;
    mag_t            r;
    m = v[DUTY_W-1] ? ({(DUTY_W+1){1'b0}} - {v[DUTY_W-1], v}) : {1'b0, v};
    if (m > limit) begin
      r.sat = 1'b1;
      r.mag = limit[DUTY_W-1:0];
    end else begin
      r.sat = 1'b0;
      r.mag = m[DUTY_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - free-running PWM period counter with boundary strobe and period_start pulse
module pwm_period_counter #(
  parameter int PWM_PERIOD = 1000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PWM_PERIOD - 1);

  assign boundary = en && (cnt == LAST);

  // period_start is registered, so it lines up with the first registered compare output of each period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= en && (cnt == '0);
      if (!en || cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_hbridge_driver.sv
// rtl/pwm_hbridge_driver.sv - H-bridge PWM driver with shadowed duty, clamp and dead period; PWM_BRAKE_EN enables short-brake at zero duty
module pwm_hbridge_driver
  import pwm_pkg::*;
#(
  parameter int PWM_PERIOD   = 1000,
  parameter int DEAD_PERIODS = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              pwm_a,
  output logic              pwm_b,
  output logic              dir,
  output logic              period_start,
  output logic [DUTY_W-1:0] duty_applied,
  output logic              sat
);

  localparam logic [DUTY_W:0] LIMIT  = (DUTY_W + 1)'(PWM_PERIOD);
  localparam logic [3:0]      DEAD_N = 4'(DEAD_PERIODS);

  logic [CNT_W-1:0]  cnt;
  logic              boundary;
  logic [DUTY_W-1:0] shadow;
  mag_t              nm;
  logic              new_dir;

  pwm_state_t        state_q, state_d;
  logic              dir_d;
  logic [DUTY_W-1:0] applied_d;
  logic              sat_d;
  logic [3:0]        dead_q, dead_d;
  logic              pwm_a_d, pwm_b_d;

  pwm_period_counter #(
    .PWM_PERIOD (PWM_PERIOD),
    .CNT_W      (CNT_W)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cnt          (cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign nm      = abs_clamp(shadow, LIMIT);
  assign new_dir = shadow[DUTY_W-1];

  // Shadow survives a disable so re-enabling resumes the last command.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (duty_valid) begin
      shadow <= duty_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dir          <= 1'b0;
      duty_applied <= '0;
      sat          <= 1'b0;
      dead_q       <= '0;
      pwm_a        <= 1'b0;
      pwm_b        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir          <= dir_d;
      duty_applied <= applied_d;
      sat          <= sat_d;
      dead_q       <= dead_d;
      pwm_a        <= pwm_a_d;
      pwm_b        <= pwm_b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir;
    applied_d = duty_applied;
    sat_d     = sat;
    dead_d    = dead_q;
    if (!en) begin
      state_d   = IDLE;
      applied_d = '0;
      sat_d     = 1'b0;
    end else if (boundary) begin
      unique case (state_q)
        IDLE: begin
          state_d   = new_dir ? REV : FWD;
          dir_d     = new_dir;
          applied_d = nm.mag;
          sat_d     = nm.sat;
        end
        FWD, REV: begin
          if (new_dir == dir || nm.mag == '0) begin
            applied_d = nm.mag;
            sat_d     = nm.sat;
          end else begin
            state_d   = DEAD;
            dead_d    = DEAD_N;
            applied_d = '0;
            sat_d     = 1'b0;
          end
        end
        DEAD: begin
          // Direction is re-read from the shadow here, so a command that flipped back resumes the old leg.
          if (dead_q <= 4'd1) begin
            dead_d    = '0;
            state_d   = new_dir ? REV : FWD;
            dir_d     = new_dir;
            applied_d = nm.mag;
            sat_d     = nm.sat;
          end else begin
            dead_d = dead_q - 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pwm_a_d = 1'b0;
    pwm_b_d = 1'b0;
    if (en) begin
      unique case (state_q)
        FWD:     pwm_a_d = (32'(cnt) < 32'(duty_applied));
        REV:     pwm_b_d = (32'(cnt) < 32'(duty_applied));
        default: ;
      endcase
`ifdef PWM_BRAKE_EN
      if ((state_q == FWD || state_q == REV) && duty_applied == '0) begin
        pwm_a_d = 1'b1;
        pwm_b_d = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// tb/tb_pwm_hbridge_driver.sv - directed table-driven bench for pwm_hbridge_driver (PWM_PERIOD=100, DEAD_PERIODS=1)
module tb_pwm_hbridge_driver;

  localparam int P = 100;
`ifdef PWM_BRAKE_EN
  localparam int BRK = P;
`else
  localparam int BRK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] duty_in = '0;
  logic        duty_valid = 1'b0;
  logic        pwm_a, pwm_b, dir, period_start, sat;
  logic [15:0] duty_applied;

  int total = 0;
  int bad = 0;
  int a_cnt, b_cnt, ps_cnt, m_dir, m_app, m_sat, n;

  typedef struct {
    logic [15:0] duty;
    int          a;
    int          b;
    int          d;
    int          app;
    int          s;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  pwm_hbridge_driver #(.PWM_PERIOD(P), .DEAD_PERIODS(1), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .pwm_a        (pwm_a),
    .pwm_b        (pwm_b),
    .dir          (dir),
    .period_start (period_start),
    .duty_applied (duty_applied),
    .sat          (sat)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_ps(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!period_start && cycles < 250);
    if (!period_start) chk("period_start_timeout", cycles, 0);
  endtask

  // Called on the negedge where period_start is high; samples one full output period.
  task automatic measure();
    a_cnt = 0; b_cnt = 0; ps_cnt = 0;
    m_dir = int'(dir); m_app = int'(duty_applied); m_sat = int'(sat);
    for (int i = 0; i < P; i++) begin
      if (i > 0) @(negedge clk);
      a_cnt += int'(pwm_a);
      b_cnt += int'(pwm_b);
      ps_cnt += int'(period_start);
    end
    chk("ps_once_per_period", ps_cnt, 1);
  endtask

  task automatic write_duty(input logic [15:0] v);
    duty_in = v;
    duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'd40,    40,  0,   0, 40,  0};
    vecs[1]  = '{16'd3000,  100, 0,   0, 100, 1};
    vecs[2]  = '{16'd60,    60,  0,   0, 60,  0};
    vecs[3]  = '{16'hFFE7,  0,   0,   0, 0,   0};
    vecs[4]  = '{16'hFFE7,  0,   25,  1, 25,  0};
    vecs[5]  = '{16'h8000,  0,   100, 1, 100, 1};
    vecs[6]  = '{16'd100,   0,   0,   1, 0,   0};
    vecs[7]  = '{16'd100,   100, 0,   0, 100, 0};
    vecs[8]  = '{16'd101,   100, 0,   0, 100, 1};
    vecs[9]  = '{16'd1,     1,   0,   0, 1,   0};
    vecs[10] = '{16'd0,     BRK, BRK, 0, 0,   0};
    vecs[11] = '{16'd99,    99,  0,   0, 99,  0};

    repeat (3) @(negedge clk);
    chk("rst_pwm_a", int'(pwm_a), 0);
    chk("rst_pwm_b", int'(pwm_b), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_applied", int'(duty_applied), 0);
    chk("rst_sat", int'(sat), 0);

    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    chk("first_ps", int'(period_start), 1);
    measure();
    chk("idle_a", a_cnt, 0);
    chk("idle_b", b_cnt, 0);
    wait_ps(n);
    chk("ps_interval", n, 1);
    measure();
    chk("zero_fwd_a", a_cnt, BRK);
    chk("zero_fwd_b", b_cnt, BRK);
    chk("zero_fwd_dir", m_dir, 0);

    for (int r = 0; r < 12; r++) begin
      wait_ps(n);
      repeat (40) @(negedge clk);
      write_duty(vecs[r].duty);
      wait_ps(n);
      measure();
      chk($sformatf("row%0d_a", r), a_cnt, vecs[r].a);
      chk($sformatf("row%0d_b", r), b_cnt, vecs[r].b);
      chk($sformatf("row%0d_dir", r), m_dir, vecs[r].d);
      chk($sformatf("row%0d_applied", r), m_app, vecs[r].app);
      chk($sformatf("row%0d_sat", r), m_sat, vecs[r].s);
    end

    // Reversal that reverts while dead: the original forward leg resumes.
    wait_ps(n);
    repeat (40) @(negedge clk);
    write_duty(16'hFFF6);
    wait_ps(n);
    chk("revert_dead_applied", int'(duty_applied), 0);
    repeat (30) @(negedge clk);
    chk("revert_dead_a", int'(pwm_a), 0);
    chk("revert_dead_b", int'(pwm_b), 0);
    write_duty(16'd20);
    wait_ps(n);
    measure();
    chk("revert_a", a_cnt, 20);
    chk("revert_b", b_cnt, 0);
    chk("revert_dir", m_dir, 0);

    // Two writes in one period: only the later one is applied.
    wait_ps(n);
    repeat (20) @(negedge clk);
    write_duty(16'd30);
    repeat (20) @(negedge clk);
    write_duty(16'd70);
    wait_ps(n);
    measure();
    chk("last_write_a", a_cnt, 70);
    chk("last_write_applied", m_app, 70);

    // Disable at cnt=50 and re-enable.
    wait_ps(n);
    repeat (49) @(negedge clk);
    chk("pre_disable_a", int'(pwm_a), 1);
    en = 1'b0;
    @(negedge clk);
    chk("disable_a", int'(pwm_a), 0);
    chk("disable_b", int'(pwm_b), 0);
    ps_cnt = 0; a_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      ps_cnt += int'(period_start);
      a_cnt += int'(pwm_a | pwm_b);
    end
    chk("disabled_ps", ps_cnt, 0);
    chk("disabled_out", a_cnt, 0);
    en = 1'b1;
    @(negedge clk);
    chk("reenable_ps", int'(period_start), 1);
    measure();
    chk("reenable_idle_a", a_cnt, 0);
    wait_ps(n);
    chk("reenable_interval", n, 1);
    measure();
    chk("reenable_shadow_a", a_cnt, 70);
    chk("reenable_dir", m_dir, 0);

    // Reset in mid-period.
    wait_ps(n);
    repeat (10) @(negedge clk);
    chk("pre_rst_a", int'(pwm_a), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_a", int'(pwm_a), 0);
    chk("midrst_applied", int'(duty_applied), 0);
    chk("midrst_ps", int'(period_start), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
